dmem_responder: RTL
===================

# dmem_responder

Synchronous doubleword memory that answers the core's memory interface: two pipelined read ports (instruction fetch and load) and one write port (store). It is the responder end of the fetch/load/store channels driven by the pipeline. It clears its own storage after reset and reports out-of-range accesses through a sticky error flag.

## Interface

- ADDR_BITS, 10: index width. DEPTH = 2^ADDR_BITS doublewords.
- LAT, 2: read latency in cycles, legal range 1..4.

- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- ready  out  1  high once init clear completes; requests are ignored while low.
- rd0_en  in  1  port-0 read request (fetch).
- rd0_addr  in  61  port-0 doubleword address, bit 0 = MSB.
- rd0_valid  out  1  one-cycle pulse marking rd0_data valid.
- rd0_data  out  64  port-0 read data; bit 0 = MSB; 0 when rd0_valid=0.
- rd1_en / rd1_addr / rd1_valid / rd1_data: same as port 0, load port.
- wr_en  in  1  write request.
- wr_addr  in  61  write doubleword address.
- wr_data  in  64  write data.
- err  out  1  sticky: any out-of-range access since reset.
- err_addr  out  61  address of the first out-of-range access.

## Operation

- Reset (rst_n low, asynchronous): ready=0, rd0/rd1_valid=0, rd0/rd1_data=0, err=0, err_addr=0. All in-flight read pipeline stages are cleared. FSM enters INIT with clear counter = 0.
- FSM INIT: each posedge writes 0 to word[counter] and increments the counter. The edge that clears word DEPTH-1 moves the FSM to READY and sets ready=1.
  - In INIT, rd*_en and wr_en are dropped: no response, no write, no err update.
- FSM READY persists until the next reset. There is no other transition.
- Address range: an address is in range iff bits [0:60-ADDR_BITS] are all zero. The index is addr[61-ADDR_BITS:60].
- Read: sampled at a posedge with en=1 and ready=1.
  - Data is captured from the array at the sampling edge, then delayed through LAT-1 further register stages.
  - In-flight data is unaffected by later writes.
  - Each port is fully pipelined: one request per cycle, responses in request order. The two ports are independent; the same address on both ports returns identical data.
- Write: committed at a posedge with wr_en=1 and ready=1.
  - Write-first: a read sampled at the same edge to the same index returns wr_data.
- Out-of-range read: still produces a valid pulse, with data = 0.
- Out-of-range write: dropped.
- Error reporting: any out-of-range access sets err. err_addr is loaded only when err was 0 before the edge.
  - Priority when several ports are out of range on the same first edge: wr, then rd1, then rd0 (highest first).

## Timing

- ready rises after exactly DEPTH posedges following rst_n deassertion.
- Read request sampled at edge k: rd*_valid=1 and rd*_data valid from edge k+LAT-1 until edge k+LAT. For LAT=1, data follows immediately after the sampling edge.
- Write at edge k is visible to reads sampled at edge k or later.
- err/err_addr update at the same edge the offending request is sampled.
- rst_n asserted mid-operation: outputs clear immediately (no clock needed). No response is ever produced for pre-reset requests. Memory is re-zeroed by a full INIT pass.

## Test plan

All scenarios use ADDR_BITS=4 (DEPTH=16) and LAT=2.

1. Release rst_n, hold rd0_en=1 at address 3 throughout → no rd0_valid during the 16 INIT edges; ready=1 after edge 16; the first response then returns 0.
2. Write 0x0123456789ABCDEF to address 5 → next cycle, rd0 address 5 → rd0_valid pulses 1 cycle after the sampling edge, rd0_data=0x0123456789ABCDEF.
3. Same edge: wr address 7 = 0xAAAA5555AAAA5555 and rd1 address 7 → rd1_data=0xAAAA5555AAAA5555. A write to 7 of 0x1 on the following edge does not alter that response.
4. Preload addresses 0..3 with 0x10..0x13. Issue rd0 on 0,1,2,3 and rd1 on 3,2,1,0 on four consecutive edges → 4 consecutive valid cycles per port. Data 0x10..0x13 on rd0 and 0x13..0x10 on rd1.
5. rd0 address 16 → valid pulse with data 0, err=1, err_addr=16. Later wr address 20 → err_addr stays 16 and no array word changes.
6. Write address 5 = 0xFF, issue rd0 address 5, assert rst_n low before the response edge → rd0_valid stays 0, ready=0. After re-init, reading address 5 returns 0.

Source files
------------

// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// Bundles the fetch (rd0), load (rd1) and store (wr) channels between the
// pipeline (master) and the doubleword memory (slave).
//   ready              memory has finished clearing itself, requests accepted
//   rd0_* / rd1_*      en/addr in, valid/data out; one request per cycle each
//   wr_*               en/addr/data in
//   err / err_addr     sticky out-of-range flag and first offending address
// Bit 0 is the MSB of every address and data vector.
// -----------------------------------------------------------------------------
interface dmem_responder_if;
  logic        ready;
  logic        rd0_en;
  logic [0:60] rd0_addr;
  logic        rd0_valid;
  logic [0:63] rd0_data;
  logic        rd1_en;
  logic [0:60] rd1_addr;
  logic        rd1_valid;
  logic [0:63] rd1_data;
  logic        wr_en;
  logic [0:60] wr_addr;
  logic [0:63] wr_data;
  logic        err;
  logic [0:60] err_addr;

  modport master (
    input  ready, rd0_valid, rd0_data, rd1_valid, rd1_data, err, err_addr,
    output rd0_en, rd0_addr, rd1_en, rd1_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    output ready, rd0_valid, rd0_data, rd1_valid, rd1_data, err, err_addr,
    input  rd0_en, rd0_addr, rd1_en, rd1_addr, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Synchronous doubleword memory serving two pipelined read ports (fetch, load)
// and one write port (store). After reset it clears every word (INIT) before
// raising ready. Out-of-range accesses set a sticky error flag and record the
// first offending address.
// Ports:
//   clk    clock, all updates on posedge
//   rst_n  asynchronous active-low reset
//   bus    dmem_responder_if.slave (read/write channels, ready, err)
// Parameters:
//   ADDR_BITS  index width, DEPTH = 2**ADDR_BITS doublewords
//   LAT        read latency in cycles (1..4)
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int ADDR_BITS = 10,
  parameter int LAT       = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_responder_if.slave   bus
);

  localparam int DEPTH = 1 << ADDR_BITS;
  // Number of upper address bits that must be zero for an in-range access.
  localparam int HI_W  = 61 - ADDR_BITS;

  typedef enum logic {ST_INIT, ST_READY} state_e;

  // Address helpers: bit 0 is the MSB, so the index is the rightmost slice.
  function automatic logic in_range(input logic [0:60] a);
    return a[0:HI_W-1] == '0;
  endfunction

  function automatic logic [ADDR_BITS-1:0] idx_of(input logic [0:60] a);
    return a[HI_W:60];
  endfunction

  // Read-word selection: out-of-range reads return 0, a same-edge write to the
  // same index wins over the stored word.
  function automatic logic [0:63] rd_word(input logic        ok,
                                          input logic        wr_hit,
                                          input logic [0:63] wdata,
                                          input logic [0:63] mword);
    if (!ok)        return '0;
    else if (wr_hit) return wdata;
    else            return mword;
  endfunction

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  state_e               state_q;
  logic [ADDR_BITS-1:0] clr_cnt_q;
  logic                 ready_q;

  logic [0:63]          mem_q [DEPTH];

  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_widx;
  logic [0:63]          mem_wdata;

  logic                 wr_ok;
  logic [ADDR_BITS-1:0] wr_idx;
  logic                 rd0_acc, rd1_acc;
  logic                 rd0_ok, rd1_ok;
  logic [ADDR_BITS-1:0] rd0_idx, rd1_idx;
  logic [0:63]          rd0_word, rd1_word;

  logic                 err_d, err_q;
  logic [0:60]          err_addr_d, err_addr_q;

  logic [LAT-1:0]       rd0_vld_p_d, rd0_vld_p_q;
  logic [LAT-1:0]       rd1_vld_p_d, rd1_vld_p_q;
  logic [0:63]          rd0_dat_p_d [LAT];
  logic [0:63]          rd0_dat_p_q [LAT];
  logic [0:63]          rd1_dat_p_d [LAT];
  logic [0:63]          rd1_dat_p_q [LAT];

  // FSM: INIT walks the clear counter across the array, READY is terminal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else if (state_q == ST_INIT) begin
      clr_cnt_q <= clr_cnt_q + ADDR_BITS'(1);
      if (clr_cnt_q == '1) begin
        state_q <= ST_READY;
        ready_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Request decode (sampling edge)
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ok    = ready_q && bus.wr_en && in_range(bus.wr_addr);
    wr_idx   = idx_of(bus.wr_addr);

    rd0_acc  = ready_q && bus.rd0_en;
    rd1_acc  = ready_q && bus.rd1_en;
    rd0_ok   = in_range(bus.rd0_addr);
    rd1_ok   = in_range(bus.rd1_addr);
    rd0_idx  = idx_of(bus.rd0_addr);
    rd1_idx  = idx_of(bus.rd1_addr);
    rd0_word = rd_word(rd0_ok, wr_ok && (wr_idx == rd0_idx), bus.wr_data, mem_q[rd0_idx]);
    rd1_word = rd_word(rd1_ok, wr_ok && (wr_idx == rd1_idx), bus.wr_data, mem_q[rd1_idx]);

    // INIT owns the write port; while rst_n is low this harmlessly re-zeroes word 0.
    if (state_q == ST_INIT) begin
      mem_we    = 1'b1;
      mem_widx  = clr_cnt_q;
      mem_wdata = '0;
    end else begin
      mem_we    = wr_ok;
      mem_widx  = wr_idx;
      mem_wdata = bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_widx] <= mem_wdata;
  end

  // Sticky error; only the first offending edge loads the address, with
  // write > load > fetch priority.
  always_comb begin
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (ready_q && !err_q) begin
      if (bus.wr_en && !in_range(bus.wr_addr)) begin
        err_d      = 1'b1;
        err_addr_d = bus.wr_addr;
      end else if (bus.rd1_en && !rd1_ok) begin
        err_d      = 1'b1;
        err_addr_d = bus.rd1_addr;
      end else if (bus.rd0_en && !rd0_ok) begin
        err_d      = 1'b1;
        err_addr_d = bus.rd0_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline: stage 0 captures at the sampling edge, stages 1..LAT-1 delay
  // ---------------------------------------------------------------------------
  always_comb begin
    rd0_vld_p_d[0] = rd0_acc;
    rd1_vld_p_d[0] = rd1_acc;
    rd0_dat_p_d[0] = rd0_word;
    rd1_dat_p_d[0] = rd1_word;
    for (int s = 1; s < LAT; s++) begin
      rd0_vld_p_d[s] = rd0_vld_p_q[s-1];
      rd1_vld_p_d[s] = rd1_vld_p_q[s-1];
      rd0_dat_p_d[s] = rd0_dat_p_q[s-1];
      rd1_dat_p_d[s] = rd1_dat_p_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd0_vld_p_q <= '0;
      rd1_vld_p_q <= '0;
    end else begin
      rd0_vld_p_q <= rd0_vld_p_d;
      rd1_vld_p_q <= rd1_vld_p_d;
    end
  end

  // Data stages need no reset: the output is masked by the valid bit.
  always_ff @(posedge clk) begin
    rd0_dat_p_q <= rd0_dat_p_d;
    rd1_dat_p_q <= rd1_dat_p_d;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.ready     = ready_q;
  assign bus.rd0_valid = rd0_vld_p_q[LAT-1];
  assign bus.rd1_valid = rd1_vld_p_q[LAT-1];
  assign bus.rd0_data  = rd0_vld_p_q[LAT-1] ? rd0_dat_p_q[LAT-1] : '0;
  assign bus.rd1_data  = rd1_vld_p_q[LAT-1] ? rd1_dat_p_q[LAT-1] : '0;
  assign bus.err       = err_q;
  assign bus.err_addr  = err_addr_q;

endmodule
